// File: rtl/uart_rx_oversampled.sv
// UART receiver driven by a 16x-oversampling tick from the baud timer.
// Synchronizes rx, finds the start bit, samples each bit at mid-bit, checks
// the stop bit and presents the word with a one-cycle done strobe.
module uart_rx_oversampled #(
    parameter int DBIT    = 8,   // data bits per frame (5..9), LSB first
    parameter int SB_TICK = 16   // ticks spent in the stop state (>= 16)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    // Tick counter must hold values up to SB_TICK-1 and at least 15.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state, state_next;

    logic            rx_sync_p0;
    logic            rx_sync_p1;
    logic            rxs;

    logic [SW-1:0]   s_cnt, s_cnt_next;
    logic [NW-1:0]   n_cnt, n_cnt_next;
    logic [DBIT-1:0] shift, shift_next;
    logic [DBIT-1:0] rx_dout_next;
    logic            rx_done_next;
    logic            frame_err_next;

    // Two-flop synchronizer; both flops idle high so reset looks like an idle line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    assign rxs = rx_sync_p1;

    // State, counters, shift register and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            shift        <= '0;
            rx_dout      <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_next;
            s_cnt        <= s_cnt_next;
            n_cnt        <= n_cnt_next;
            shift        <= shift_next;
            rx_dout      <= rx_dout_next;
            rx_done_tick <= rx_done_next;
            frame_err    <= frame_err_next;
        end
    end

    // Next-state and datapath updates; everything except the IDLE exit waits on s_tick
    always_comb begin
        state_next     = state;
        s_cnt_next     = s_cnt;
        n_cnt_next     = n_cnt;
        shift_next     = shift;
        rx_dout_next   = rx_dout;
        rx_done_next   = 1'b0;
        frame_err_next = frame_err;

        unique case (state)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                    s_cnt_next = '0;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s_cnt == SW'(7)) begin
                        // Still low at mid start bit: real frame; otherwise a glitch
                        if (!rxs) begin
                            state_next = DATA;
                            s_cnt_next = '0;
                            n_cnt_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_cnt_next = s_cnt + SW'(1);
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s_cnt == SW'(15)) begin
                        s_cnt_next = '0;
                        shift_next = {rxs, shift[DBIT-1:1]};
                        if (n_cnt == NW'(DBIT - 1)) begin
                            state_next = STOP;
                        end else begin
                            n_cnt_next = n_cnt + NW'(1);
                        end
                    end else begin
                        s_cnt_next = s_cnt + SW'(1);
                    end
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (s_cnt == SW'(SB_TICK - 1)) begin
                        // Word is delivered even when the stop bit is bad
                        state_next     = IDLE;
                        rx_dout_next   = shift;
                        frame_err_next = ~rxs;
                        rx_done_next   = 1'b1;
                    end else begin
                        s_cnt_next = s_cnt + SW'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled (8N1, tick every 4 clk).
// The sender pushes {frame_err, data} per complete frame; a monitor pops on
// each rx_done_tick and compares.
module tb_uart_rx_oversampled;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            rx = 1'b1;
    logic            s_tick = 1'b0;
    logic [DBIT-1:0] rx_dout;
    logic            rx_done_tick;
    logic            frame_err;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    logic        tick_en = 1'b1;
    int          phase = 0;

    logic [8:0]  exp_q[$];
    int          done_count = 0;
    int unsigned done_cyc = 0;
    int unsigned start_cyc = 0;
    logic        prev_done = 1'b0;
    logic [8:0]  mon_e;

    uart_rx_oversampled #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .rx_dout      (rx_dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tick generator: one-clk pulse every 4 clk, masked by tick_en for stalls
    initial begin
        forever begin
            @(negedge clk);
            phase  = (phase + 1) % 4;
            s_tick = tick_en && (phase == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected frame
    always @(negedge clk) begin
        if (rx_done_tick) begin
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {24'd0, rx_dout}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_dout", {24'd0, rx_dout}, {24'd0, mon_e[7:0]});
                check("frame_err", {31'd0, frame_err}, {31'd0, mon_e[8]});
            end
            done_count++;
            done_cyc = cyc;
        end
        prev_done = rx_done_tick;
    end

    // Wait for n ticks seen by the DUT, bounded by a cycle budget
    task automatic wait_ticks(input int n);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 2000) begin
            @(posedge clk);
            budget++;
            if (s_tick) got++;
        end
        if (got < n) check("tick_timeout", got, n);
    endtask

    task automatic align();
        wait_ticks(1);
    endtask

    task automatic send_bit(input logic b, input int n);
        @(negedge clk);
        rx = b;
        wait_ticks(n);
    endtask

    // One frame, 16 ticks per bit. A bad stop bit is held low only across its
    // sample point and then released, so the receiver's re-arm in the low half
    // of the stop bit sees a glitch rather than a false start.
    task automatic send_frame(input logic [7:0] data, input logic good_stop, input int stall_bit);
        exp_q.push_back({~good_stop, data});
        @(negedge clk);
        rx = 1'b0;
        start_cyc = cyc;
        wait_ticks(16);
        for (int i = 0; i < DBIT; i++) begin
            if (i == stall_bit) begin
                @(negedge clk);
                rx = data[i];
                wait_ticks(8);
                @(negedge clk);
                tick_en = 1'b0;
                repeat (100) @(negedge clk);
                tick_en = 1'b1;
                wait_ticks(8);
            end else begin
                send_bit(data[i], 16);
            end
        end
        if (good_stop) begin
            send_bit(1'b1, SB_TICK);
        end else begin
            send_bit(1'b0, 10);
            send_bit(1'b1, 6 + 16);
        end
    endtask

    initial begin
        int lat_base;
        int lat;
        int expected_count;
        logic [7:0] d;
        logic g;
        int gap;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_dout", {24'd0, rx_dout}, 32'd0);
            check("rst_done", {31'd0, rx_done_tick}, 32'd0);
            check("rst_ferr", {31'd0, frame_err}, 32'd0);
        end
        reset = 1'b0;
        repeat (500) @(negedge clk);
        check("idle_no_pulse", done_count, 0);

        // Single frame 0xA5 and its latency from the falling edge (152 ticks = 608 clk)
        align();
        send_frame(8'hA5, 1'b1, -1);
        lat_base = int'(done_cyc - start_cyc);
        check("latency_8n1_in_range", {31'd0, (lat_base >= 600 && lat_base <= 616)}, 32'd1);
        check("single_count", done_count, 1);

        // Back-to-back with no idle gap
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        check("b2b_count", done_count, 3);

        // Start glitch of 3 ticks, then a good frame
        @(negedge clk);
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_pulse", done_count, 3);
        align();
        send_frame(8'h3C, 1'b1, -1);
        check("after_glitch_count", done_count, 4);

        // Framing error followed by a good frame
        send_frame(8'h55, 1'b0, -1);
        send_frame(8'h81, 1'b1, -1);
        check("ferr_count", done_count, 6);

        // Reset after 4 data bits of 0xF0: asynchronous clear, no pulse
        align();
        d = 8'hF0;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(d[i], 16);
        #3;
        reset = 1'b1;
        rx    = 1'b1;
        #1;
        check("async_rst_dout", {24'd0, rx_dout}, 32'd0);
        check("async_rst_done", {31'd0, rx_done_tick}, 32'd0);
        check("async_rst_ferr", {31'd0, frame_err}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (800) @(negedge clk);
        check("rst_abort_no_pulse", done_count, 6);

        // Tick stall of 100 clk in the middle of data bit 3
        align();
        send_frame(8'h96, 1'b1, 3);
        lat = int'(done_cyc - start_cyc);
        check("stall_latency", lat, lat_base + 100);
        check("stall_count", done_count, 7);

        // Randomized frames: random data, occasional bad stop, 0..2 tick gaps
        expected_count = 7;
        for (int k = 0; k < 24; k++) begin
            d   = 8'($urandom);
            g   = ($urandom % 4) != 0;
            gap = int'($urandom % 3);
            if (gap > 0) wait_ticks(gap);
            send_frame(d, g, -1);
            expected_count++;
        end
        repeat (50) @(negedge clk);
        check("random_count", done_count, expected_count);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
